// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: widths, ALU op codes and the ID/EX payload record.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_LUI    = 4'd10,
    ALU_PASS_B = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] store_data;
    logic [RAW-1:0]  rd_addr;
    logic            rd_en;
    logic            mem_rd;
    logic            mem_wr;
    alu_op_e         alu_op;
  } idex_payload_t;

  // Empty slot holds a canonical NOP so EX never sees an undefined encoding.
  function automatic idex_payload_t idex_reset_payload();
    idex_payload_t p;
    p       = '0;
    p.instr = NOP_INSTR;
    return p;
  endfunction

endpackage

// File: rtl/idex_hazard.sv
// Load-use comparator: flags a consumer in decode that reads the rd of a load held in ID/EX.
module idex_hazard #(
  parameter int RAW = riscv_pkg::RAW
) (
  input  logic           ex_valid,
  input  logic           ex_mem_rd,
  input  logic           ex_rd_en,
  input  logic [RAW-1:0] ex_rd_addr,
  input  logic           id_valid,
  input  logic           id_rs1_en,
  input  logic           id_rs2_en,
  input  logic [RAW-1:0] id_rs1_addr,
  input  logic [RAW-1:0] id_rs2_addr,
  output logic           hazard_stall
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit      = id_rs1_en && (id_rs1_addr == ex_rd_addr);
    rs2_hit      = id_rs2_en && (id_rs2_addr == ex_rd_addr);
    hazard_stall = ex_valid && ex_mem_rd && ex_rd_en && id_valid && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/idex_stage.sv
// Decode-to-execute pipeline register with valid/ready handshake, flush and stall.
// Define IDEX_LOADUSE_EN to insert load-use bubbles here via idex_hazard.
module idex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int RAW  = riscv_pkg::RAW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_instr,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RAW-1:0]  id_rs1_addr,
  input  logic [RAW-1:0]  id_rs2_addr,
  input  logic [RAW-1:0]  id_rd_addr,
  input  logic            id_rs1_en,
  input  logic            id_rs2_en,
  input  logic            id_rd_en,
  input  logic [3:0]      id_alu_op,
  input  logic            id_src_b_imm,
  input  logic            id_mem_rd,
  input  logic            id_mem_wr,
  input  logic [XLEN-1:0] idexreg_r_data1,
  input  logic [XLEN-1:0] idexreg_r_data2,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_instr,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_op_a,
  output logic [XLEN-1:0] ex_op_b,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RAW-1:0]  ex_rd_addr,
  output logic            ex_rd_en,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr,
  output logic [3:0]      ex_alu_op,
  output logic            hazard_stall
);

  idex_payload_t pay_p0;
  idex_payload_t pay_p1;
  logic          vld_p1;
  logic          accept;
  logic          drain;

  // Decode side (p0): assemble the payload, operand B muxed here so EX gets it registered.
  always_comb begin
    pay_p0            = '0;
    pay_p0.pc         = id_pc;
    pay_p0.instr      = id_instr;
    pay_p0.imm        = id_imm;
    pay_p0.op_a       = idexreg_r_data1;
    pay_p0.op_b       = id_src_b_imm ? id_imm : idexreg_r_data2;
    pay_p0.store_data = idexreg_r_data2;
    pay_p0.rd_addr    = id_rd_addr;
    pay_p0.rd_en      = id_rd_en && (id_rd_addr != '0);
    pay_p0.mem_rd     = id_mem_rd;
    pay_p0.mem_wr     = id_mem_wr;
    pay_p0.alu_op     = alu_op_e'(id_alu_op);
  end

`ifdef IDEX_LOADUSE_EN
  idex_hazard #(.RAW(RAW)) u_hazard (
    .ex_valid     (vld_p1),
    .ex_mem_rd    (pay_p1.mem_rd),
    .ex_rd_en     (pay_p1.rd_en),
    .ex_rd_addr   (pay_p1.rd_addr),
    .id_valid     (id_valid),
    .id_rs1_en    (id_rs1_en),
    .id_rs2_en    (id_rs2_en),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .hazard_stall (hazard_stall)
  );
`else
  // Source-register fields only feed the load-use check; here they are terminated.
  assign hazard_stall = 1'b0 & (id_rs1_en | id_rs2_en | (|id_rs1_addr) | (|id_rs2_addr));
`endif

  assign id_ready = (!vld_p1 || ex_ready) && !hazard_stall;
  assign accept   = id_valid && id_ready;
  assign drain    = vld_p1 && ex_ready;

  // Execute side (p1): flush beats accept; a stalled load drains into a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      pay_p1 <= idex_reset_payload();
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
      pay_p1 <= pay_p0;
    end else if (drain) begin
      vld_p1 <= 1'b0;
    end
  end

  assign ex_valid      = vld_p1;
  assign ex_pc         = pay_p1.pc;
  assign ex_instr      = pay_p1.instr;
  assign ex_imm        = pay_p1.imm;
  assign ex_op_a       = pay_p1.op_a;
  assign ex_op_b       = pay_p1.op_b;
  assign ex_store_data = pay_p1.store_data;
  assign ex_rd_addr    = pay_p1.rd_addr;
  assign ex_rd_en      = pay_p1.rd_en;
  assign ex_mem_rd     = pay_p1.mem_rd;
  assign ex_mem_wr     = pay_p1.mem_wr;
  assign ex_alu_op     = pay_p1.alu_op;

endmodule

// File: tb/tb_idex_stage.sv
// Scoreboard bench for idex_stage; load-use expectations follow IDEX_LOADUSE_EN.
`timescale 1ns/1ps
module tb_idex_stage;

`ifdef IDEX_LOADUSE_EN
  localparam bit LOADUSE = 1'b1;
`else
  localparam bit LOADUSE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_instr, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_rs1_en, id_rs2_en, id_rd_en;
  logic [3:0]  id_alu_op;
  logic        id_src_b_imm, id_mem_rd, id_mem_wr;
  logic [31:0] idexreg_r_data1, idexreg_r_data2;
  logic        flush, ex_ready, ex_valid;
  logic [31:0] ex_pc, ex_instr, ex_imm, ex_op_a, ex_op_b, ex_store_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_en, ex_mem_rd, ex_mem_wr;
  logic [3:0]  ex_alu_op;
  logic        hazard_stall;

  idex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_instr(id_instr), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en), .id_rd_en(id_rd_en),
    .id_alu_op(id_alu_op), .id_src_b_imm(id_src_b_imm),
    .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
    .idexreg_r_data1(idexreg_r_data1), .idexreg_r_data2(idexreg_r_data2),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_imm(ex_imm),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_store_data(ex_store_data),
    .ex_rd_addr(ex_rd_addr), .ex_rd_en(ex_rd_en), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_alu_op(ex_alu_op), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc, instr, imm, d1, d2;
    logic [4:0]  rs1, rs2, rd;
    logic        rs1_en, rs2_en, rd_en;
    logic [3:0]  op;
    logic        bimm, mrd, mwr;
  } id_t;

  typedef struct {
    logic [31:0] pc, instr, imm, op_a, op_b, sd;
    logic [4:0]  rd;
    logic        rd_en, mrd, mwr;
    logic [3:0]  op;
  } exp_t;

  exp_t exp_q[$];
  bit   m_vld;
  int   n_chk, n_pass;
  id_t  idle;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  function automatic id_t mk(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] imm,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic rs1_en, input logic rs2_en, input logic rd_en,
                             input logic [3:0] op, input logic bimm, input logic mrd, input logic mwr,
                             input logic [31:0] d1, input logic [31:0] d2);
    id_t s;
    s.v = 1'b1; s.pc = pc; s.instr = instr; s.imm = imm; s.d1 = d1; s.d2 = d2;
    s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.rs1_en = rs1_en; s.rs2_en = rs2_en; s.rd_en = rd_en;
    s.op = op; s.bimm = bimm; s.mrd = mrd; s.mwr = mwr;
    return s;
  endfunction

  function automatic exp_t mk_exp(input id_t s);
    exp_t e;
    e.pc = s.pc; e.instr = s.instr; e.imm = s.imm;
    e.op_a = s.d1;
    e.op_b = s.bimm ? s.imm : s.d2;
    e.sd = s.d2;
    e.rd = s.rd;
    e.rd_en = s.rd_en && (s.rd != 5'd0);
    e.mrd = s.mrd; e.mwr = s.mwr; e.op = s.op;
    return e;
  endfunction

  task automatic drive(input id_t s, input bit fl, input bit rdy);
    rst = 1'b0;
    id_valid = s.v; id_pc = s.pc; id_instr = s.instr; id_imm = s.imm;
    id_rs1_addr = s.rs1; id_rs2_addr = s.rs2; id_rd_addr = s.rd;
    id_rs1_en = s.rs1_en; id_rs2_en = s.rs2_en; id_rd_en = s.rd_en;
    id_alu_op = s.op; id_src_b_imm = s.bimm; id_mem_rd = s.mrd; id_mem_wr = s.mwr;
    idexreg_r_data1 = s.d1; idexreg_r_data2 = s.d2;
    flush = fl; ex_ready = rdy;
  endtask

  task automatic check_ex();
    chk("ex_valid", 32'(ex_valid), 32'(m_vld));
    if (m_vld) begin
      exp_t e;
      e = exp_q[0];
      chk("ex_pc", ex_pc, e.pc);
      chk("ex_instr", ex_instr, e.instr);
      chk("ex_imm", ex_imm, e.imm);
      chk("ex_op_a", ex_op_a, e.op_a);
      chk("ex_op_b", ex_op_b, e.op_b);
      chk("ex_store_data", ex_store_data, e.sd);
      chk("ex_rd_addr", 32'(ex_rd_addr), 32'(e.rd));
      chk("ex_rd_en", 32'(ex_rd_en), 32'(e.rd_en));
      chk("ex_mem_rd", 32'(ex_mem_rd), 32'(e.mrd));
      chk("ex_mem_wr", 32'(ex_mem_wr), 32'(e.mwr));
      chk("ex_alu_op", 32'(ex_alu_op), 32'(e.op));
    end
  endtask

  task automatic cycle(input id_t s, input bit fl, input bit rdy, output bit acc);
    bit   stall, rdy_exp, drn;
    exp_t f;
    @(negedge clk);
    drive(s, fl, rdy);
    #1;
    stall = 1'b0;
    if (LOADUSE && m_vld && s.v && exp_q.size() > 0) begin
      f = exp_q[0];
      stall = f.mrd && f.rd_en &&
              ((s.rs1_en && s.rs1 == f.rd) || (s.rs2_en && s.rs2 == f.rd));
    end
    rdy_exp = (!m_vld || rdy) && !stall;
    chk("hazard_stall", 32'(hazard_stall), 32'(stall));
    chk("id_ready", 32'(id_ready), 32'(rdy_exp));
    acc = s.v && rdy_exp;
    drn = m_vld && rdy;
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
      m_vld = 1'b0;
    end else if (acc) begin
      if (m_vld) void'(exp_q.pop_front());
      exp_q.push_back(mk_exp(s));
      m_vld = 1'b1;
    end else if (drn) begin
      void'(exp_q.pop_front());
      m_vld = 1'b0;
    end
    check_ex();
  endtask

  task automatic offer(input id_t s);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) cycle(s, 1'b0, 1'b1, acc);
    if (!acc) begin
      n_chk++;
      $display("FAIL offer_timeout: pc %h still not accepted after 8 cycles", s.pc);
    end
  endtask

  task automatic do_reset(input bit rdy);
    @(negedge clk);
    rst = 1'b1;
    ex_ready = rdy;
    @(posedge clk);
    #1;
    exp_q.delete();
    m_vld = 1'b0;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_instr", ex_instr, 32'h00000013);
    chk("rst_ex_pc", ex_pc, 32'd0);
    chk("rst_ex_op_a", ex_op_a, 32'd0);
    chk("rst_ex_store_data", ex_store_data, 32'd0);
    chk("rst_ex_rd_en", 32'(ex_rd_en), 32'd0);
    chk("rst_hazard_stall", 32'(hazard_stall), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    id_t addi, add2, sub4, xor5, or6, and7, lw5, add_lu, add_nolu, sw7, nop0, r;
    bit  acc;
    n_chk = 0; n_pass = 0; m_vld = 1'b0;
    idle = '{default: '0};
    drive(idle, 1'b0, 1'b1);
    rst = 1'b1;

    addi     = mk(32'h100, 32'h00500093, 32'd5, 5'd0, 5'd0, 5'd1, 1, 0, 1, 4'd0, 1, 0, 0, 32'd0, 32'd0);
    add2     = mk(32'h104, 32'h00108133, 32'd0, 5'd1, 5'd1, 5'd2, 1, 1, 1, 4'd0, 0, 0, 0, 32'd5, 32'd5);
    sub4     = mk(32'h108, 32'h40208233, 32'd0, 5'd1, 5'd2, 5'd4, 1, 1, 1, 4'd1, 0, 0, 0, 32'd5, 32'd10);
    xor5     = mk(32'h10c, 32'h0020c2b3, 32'd0, 5'd1, 5'd2, 5'd5, 1, 1, 1, 4'd5, 0, 0, 0, 32'h0f0f0f0f, 32'hff00ff00);
    or6      = mk(32'h110, 32'h0020e333, 32'd0, 5'd1, 5'd2, 5'd6, 1, 1, 1, 4'd8, 0, 0, 0, 32'h1, 32'h2);
    and7     = mk(32'h114, 32'h0020f3b3, 32'd0, 5'd1, 5'd2, 5'd7, 1, 1, 1, 4'd9, 0, 0, 0, 32'h3, 32'h6);
    lw5      = mk(32'h200, 32'h00012283, 32'd0, 5'd2, 5'd0, 5'd5, 1, 0, 1, 4'd0, 1, 1, 0, 32'h1000, 32'd0);
    add_lu   = mk(32'h204, 32'h00128333, 32'd0, 5'd5, 5'd1, 5'd6, 1, 1, 1, 4'd0, 0, 0, 0, 32'h77, 32'h11);
    add_nolu = mk(32'h20c, 32'h00100333, 32'd0, 5'd0, 5'd1, 5'd6, 1, 1, 1, 4'd0, 0, 0, 0, 32'd0, 32'h11);
    sw7      = mk(32'h300, 32'h00712223, 32'd4, 5'd2, 5'd7, 5'd4, 1, 1, 0, 4'd0, 1, 0, 1, 32'h1000, 32'hDEADBEEF);
    nop0     = mk(32'h304, 32'h00000013, 32'd0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 4'd0, 1, 0, 0, 32'd0, 32'd0);

    do_reset(1'b1);

    // back-to-back stream at full throughput
    cycle(addi, 1'b0, 1'b1, acc);
    cycle(add2, 1'b0, 1'b1, acc);
    cycle(idle, 1'b0, 1'b1, acc);

    // entry held for three cycles, then drains while the next one enters
    cycle(sub4, 1'b0, 1'b0, acc);
    repeat (3) cycle(xor5, 1'b0, 1'b0, acc);
    cycle(xor5, 1'b0, 1'b1, acc);
    cycle(idle, 1'b0, 1'b1, acc);

    // flush discards a same-cycle accept, and also a held entry
    cycle(or6, 1'b1, 1'b1, acc);
    cycle(and7, 1'b0, 1'b1, acc);
    cycle(sub4, 1'b0, 1'b0, acc);
    cycle(idle, 1'b1, 1'b0, acc);
    cycle(idle, 1'b0, 1'b1, acc);

    // load-use pair, then load followed by an independent add
    offer(lw5);
    offer(add_lu);
    cycle(idle, 1'b0, 1'b1, acc);
    offer(lw5);
    offer(add_nolu);
    cycle(idle, 1'b0, 1'b1, acc);

    // store operand routing and rd_en suppression for x0
    offer(sw7);
    offer(nop0);
    cycle(idle, 1'b0, 1'b1, acc);

    // random traffic with back-pressure and flushes
    for (int i = 0; i < 60; i++) begin
      r = mk(32'h400 + 32'(i * 4), $urandom, $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
      r.v = ($urandom_range(0, 9) < 7);
      cycle(r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7), acc);
    end

    // reset while an entry is stalled drops it
    cycle(sub4, 1'b0, 1'b0, acc);
    cycle(idle, 1'b0, 1'b0, acc);
    do_reset(1'b0);
    cycle(addi, 1'b0, 1'b1, acc);
    cycle(idle, 1'b0, 1'b1, acc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/idex_stage.md
# idex_stage

Decode-to-execute pipeline stage of the RISC-V core. Captures the decoded instruction, control fields and the two operands produced combinationally by `regbag` in the decode cycle, and holds them for the execute stage under a valid/ready handshake with stall, flush and optional load-use bubble insertion. Sits between the decoder/`regbag` read ports (upstream) and the ALU/EX stage (downstream).

## Interface
- `XLEN`, 32, datapath width
- `RAW`, 5, register address width
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `id_valid`  in  1  decode holds a valid instruction
- `id_ready`  out  1  stage accepts this cycle
- `id_pc`, `id_instr`, `id_imm`  in  XLEN each  PC, raw instruction, sign-extended immediate
- `id_rs1_addr`, `id_rs2_addr`, `id_rd_addr`  in  RAW each  source/destination registers
- `id_rs1_en`, `id_rs2_en`, `id_rd_en`  in  1 each  source-used / writes-rd flags
- `id_alu_op`  in  4  ALU operation code
- `id_src_b_imm`, `id_mem_rd`, `id_mem_wr`  in  1 each  operand-B select, load, store
- `idexreg_r_data1`, `idexreg_r_data2`  in  XLEN each  `regbag` read data (already WB-bypassed, zero for x0/disabled)
- `flush`  in  1  squash from branch/jump resolution
- `ex_ready`  in  1  EX consumes this cycle
- `ex_valid`  out  1  held entry valid
- `ex_pc`, `ex_instr`, `ex_imm`, `ex_op_a`, `ex_op_b`, `ex_store_data`  out  XLEN each
- `ex_rd_addr`  out  RAW;  `ex_rd_en`, `ex_mem_rd`, `ex_mem_wr`  out  1 each;  `ex_alu_op`  out  4
- `hazard_stall`  out  1  load-use bubble being inserted this cycle

## Operation
- Single-entry register; accept = `id_valid && id_ready`; drain = `ex_valid && ex_ready`.
- `id_ready = (!ex_valid || ex_ready) && !hazard_stall`.
- Capture: `ex_op_a <= idexreg_r_data1`; `ex_op_b <= id_src_b_imm ? id_imm : idexreg_r_data2`; `ex_store_data <= idexreg_r_data2`; other fields copied verbatim.
- Drain without accept -> `ex_valid <= 0` (payload may hold stale values).
- `ex_valid && !ex_ready` -> entire payload and `ex_valid` held bit-exact.
- `flush` priority over everything: next cycle `ex_valid = 0`; an accept in the same cycle is discarded. Upstream squashes itself.
- `ex_rd_en` forced 0 when `id_rd_addr == 0`.
- Operand forwarding from MEM/WB into EX is not done here; EX owns it.

## Timing
- Latency 1 cycle: accept at edge N -> `ex_valid` and payload visible after edge N.
- `id_ready` and `hazard_stall` combinational from current-cycle inputs and held state; no combinational path from `id_*` payload to `ex_*`.
- Reset (`rst` high at edge): `ex_valid = 0`, all payload 0 except `ex_instr = 32'h00000013` (NOP); `hazard_stall = 0` after reset. Reset mid-transfer drops the entry.
- Back-to-back accept every cycle while `ex_ready = 1` (full throughput).

## Configuration
- `IDEX_LOADUSE_EN` defined: `hazard_stall = ex_valid && ex_mem_rd && ex_rd_en && id_valid && ((id_rs1_en && id_rs1_addr == ex_rd_addr) || (id_rs2_en && id_rs2_addr == ex_rd_addr))`. While high, `id_ready = 0`; if `ex_ready`, a bubble (`ex_valid <= 0`) follows the load. Exactly one bubble per load-use pair.
- Not defined: `hazard_stall` tied 0; decoder/hazard unit is responsible for load-use stalls.

## Structure
- Shared package `riscv_pkg`: `XLEN`, `RAW`, ALU op enum (4 bit), `NOP_INSTR = 32'h00000013`, ID/EX payload struct.
- One sub-module `idex_hazard`: load-use comparator, instantiated only under `IDEX_LOADUSE_EN`.

## Test plan
- Reset then stream `addi x1,x0,5` / `add x2,x1,x1` with `ex_ready = 1` -> `ex_valid` high from cycle 1, one instruction per cycle, `ex_op_b = 5` for the addi.
- `ex_ready = 0` for 3 cycles with entry held -> `id_ready = 0`, payload unchanged bit-exact, then drains on the cycle `ex_ready` rises.
- `flush` asserted together with an accept -> next cycle `ex_valid = 0`; following accept proceeds normally.
- `IDEX_LOADUSE_EN`: `lw x5,0(x2)` then `add x6,x5,x1` -> `hazard_stall = 1` one cycle, one bubble, add enters the stage one cycle late; same with `add x6,x0,x1` -> no stall.
- Store `sw x7,4(x2)` with `x7 = 0xDEADBEEF`, imm 4 -> `ex_op_b = 4`, `ex_store_data = 0xDEADBEEF`, `ex_rd_en = 0`.
- Assert `rst` while `ex_valid = 1` and `ex_ready = 0` -> next cycle `ex_valid = 0`, `ex_instr = 0x00000013`.
